// File: rtl/button_scan_arbiter.sv
// Four-button debouncer sharing one settle-window timer among all buttons.
// A round-robin arbiter picks which unsettled button the timer watches next.
module button_scan_arbiter #(
    parameter logic sim          = 1'b0,
    parameter int   settle_ticks = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in,
    output logic [3:0] stable,
    output logic [3:0] press,
    output logic [3:0] release_pulse,
    output logic       busy,
    output logic [1:0] owner
);

    localparam int DIV   = sim ? 2 : 100000;
    localparam int DIV_W = $clog2(DIV);
    localparam int WIN_W = $clog2(settle_ticks + 1);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         sync1_reg, sync_reg;
    logic [DIV_W-1:0]   div_reg;
    logic               tick;
    logic [WIN_W-1:0]   win_reg, win_next;
    logic [1:0]         owner_reg, owner_next;
    logic [1:0]         ptr_reg, ptr_next;
    logic [3:0]         stable_reg, stable_next;
    logic [3:0]         press_reg, press_next;
    logic [3:0]         release_reg, release_next;
    logic [3:0]         cand;
    logic [3:0]         rot_cand;
    logic [1:0]         grant_off;
    logic               grant_valid;

    assign tick = (div_reg == DIV_W'(DIV - 1));
    assign cand = sync_reg ^ stable_reg;

    // Rotate candidates so that offset 0 is the button at ptr.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot_cand[gi] = cand[ptr_reg + 2'(gi)];
    end

    always_comb begin
        grant_valid = |rot_cand;
        grant_off   = 2'd0;
        if (rot_cand[0])      grant_off = 2'd0;
        else if (rot_cand[1]) grant_off = 2'd1;
        else if (rot_cand[2]) grant_off = 2'd2;
        else if (rot_cand[3]) grant_off = 2'd3;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg   <= '0;
            sync_reg    <= '0;
            div_reg     <= '0;
            state_reg   <= IDLE;
            win_reg     <= '0;
            owner_reg   <= '0;
            ptr_reg     <= '0;
            stable_reg  <= '0;
            press_reg   <= '0;
            release_reg <= '0;
        end else begin
            sync1_reg   <= in;
            sync_reg    <= sync1_reg;
            div_reg     <= tick ? '0 : div_reg + 1'b1;
            state_reg   <= state_next;
            win_reg     <= win_next;
            owner_reg   <= owner_next;
            ptr_reg     <= ptr_next;
            stable_reg  <= stable_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        win_next     = win_reg;
        owner_next   = owner_reg;
        ptr_next     = ptr_reg;
        stable_next  = stable_reg;
        press_next   = '0;
        release_next = '0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    owner_next = ptr_reg + grant_off;
                    win_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (tick) begin
                    win_next = win_reg + 1'b1;
                    if (win_reg == WIN_W'(settle_ticks - 1))
                        state_next = CHECK;
                end
            end
            CHECK: begin
                // Only the level seen now counts; a bounce back is dropped silently.
                if (sync_reg[owner_reg] != stable_reg[owner_reg]) begin
                    stable_next[owner_reg] = sync_reg[owner_reg];
                    if (sync_reg[owner_reg])
                        press_next[owner_reg] = 1'b1;
                    else
                        release_next[owner_reg] = 1'b1;
                end
                ptr_next   = owner_reg + 2'd1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign stable        = stable_reg;
    assign press         = press_reg;
    assign release_pulse = release_reg;
    assign owner         = owner_reg;
    assign busy          = (state_reg == WAIT) || (state_reg == CHECK);

endmodule

// File: tb/tb_button_scan_arbiter.sv
// Directed bench for button_scan_arbiter with the fast divider and a 10-tick window.
module tb_button_scan_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] in;
    logic [3:0] stable;
    logic [3:0] press;
    logic [3:0] release_pulse;
    logic       busy;
    logic [1:0] owner;

    int total = 0;
    int bad   = 0;

    button_scan_arbiter #(.sim(1'b1), .settle_ticks(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .in            (in),
        .stable        (stable),
        .press         (press),
        .release_pulse (release_pulse),
        .busy          (busy),
        .owner         (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_pulse(input int limit, output int cyc,
                              output logic [3:0] p, output logic [3:0] r);
        cyc = 0;
        p   = '0;
        r   = '0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if ((press | release_pulse) != 4'b0000) begin
                p = press;
                r = release_pulse;
                break;
            end
        end
    endtask

    task automatic wait_busy(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (busy) break;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        in    = 4'b0000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({stable, press, release_pulse, busy, owner} !== 15'd0) begin
            bad++;
            $display("FAIL reset_state: got stable=%b press=%b release=%b busy=%b owner=%0d, want all 0",
                     stable, press, release_pulse, busy, owner);
        end
    endtask

    task automatic test_single_press();
        int cyc;
        logic [3:0] p, r;
        in = 4'b0001;
        wait_busy(10);
        total++;
        if (busy !== 1'b1 || owner !== 2'd0) begin
            bad++;
            $display("FAIL single_grant: got busy=%b owner=%0d, want busy=1 owner=0", busy, owner);
        end
        wait_pulse(60, cyc, p, r);
        total++;
        if (p !== 4'b0001 || r !== 4'b0000 || stable !== 4'b0001) begin
            bad++;
            $display("FAIL single_press: got press=%b release=%b stable=%b, want 0001 0000 0001", p, r, stable);
        end
        total++;
        if (cyc < 15 || cyc > 30) begin
            bad++;
            $display("FAIL single_latency: got %0d cycles, want 15..30", cyc);
        end
        @(negedge clk);
        total++;
        if (press !== 4'b0000) begin
            bad++;
            $display("FAIL single_width: got press=%b one cycle later, want 0000", press);
        end
        in = 4'b0000;
        wait_pulse(60, cyc, p, r);
        total++;
        if (r !== 4'b0001 || p !== 4'b0000 || stable !== 4'b0000) begin
            bad++;
            $display("FAIL single_release: got press=%b release=%b stable=%b, want 0000 0001 0000", p, r, stable);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] seen;
        seen = '0;
        @(negedge clk);
        in = 4'b0001;
        wait_busy(10);
        repeat (5) @(negedge clk);
        in = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen |= press | release_pulse;
            if (!busy) break;
        end
        repeat (4) begin
            @(negedge clk);
            seen |= press | release_pulse;
        end
        total++;
        if (stable !== 4'b0000 || seen !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bounce: got stable=%b pulses=%b busy=%b, want 0000 0000 0", stable, seen, busy);
        end
    endtask

    task automatic test_all_press();
        int cyc;
        logic [3:0] p, r, expv;
        apply_reset();
        in = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            expv = 4'b0001 << k;
            wait_pulse(60, cyc, p, r);
            total++;
            if (p !== expv || r !== 4'b0000) begin
                bad++;
                $display("FAIL all_press_%0d: got press=%b release=%b, want press=%b", k, p, r, expv);
            end
        end
        total++;
        if (stable !== 4'b1111) begin
            bad++;
            $display("FAIL all_press_stable: got %b, want 1111", stable);
        end
    endtask

    task automatic test_release();
        int cyc;
        logic [3:0] p, r, expv;
        in = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            expv = (k == 2) ? 4'b1000 : (4'b0001 << k);
            wait_pulse(60, cyc, p, r);
            total++;
            if (r !== expv || p !== 4'b0000) begin
                bad++;
                $display("FAIL release_order_%0d: got release=%b press=%b, want release=%b", k, r, p, expv);
            end
        end
        total++;
        if (stable !== 4'b0100) begin
            bad++;
            $display("FAIL release_mid_stable: got %b, want 0100", stable);
        end
        in = 4'b0000;
        wait_pulse(60, cyc, p, r);
        total++;
        if (r !== 4'b0100 || p !== 4'b0000 || stable !== 4'b0000) begin
            bad++;
            $display("FAIL release_btn2: got release=%b press=%b stable=%b, want 0100 0000 0000", r, p, stable);
        end
        @(negedge clk);
        total++;
        if (release_pulse !== 4'b0000) begin
            bad++;
            $display("FAIL release_width: got %b one cycle later, want 0000", release_pulse);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        logic [3:0] p, r;
        in = 4'b1001;
        wait_busy(10);
        total++;
        if (owner !== 2'd3) begin
            bad++;
            $display("FAIL wrap_first_owner: got %0d, want 3", owner);
        end
        wait_pulse(60, cyc, p, r);
        total++;
        if (p !== 4'b1000) begin
            bad++;
            $display("FAIL wrap_first_press: got %b, want 1000", p);
        end
        wait_busy(10);
        total++;
        if (owner !== 2'd0) begin
            bad++;
            $display("FAIL wrap_second_owner: got %0d, want 0", owner);
        end
        wait_pulse(60, cyc, p, r);
        total++;
        if (p !== 4'b0001 || stable !== 4'b1001) begin
            bad++;
            $display("FAIL wrap_second_press: got press=%b stable=%b, want 0001 1001", p, stable);
        end
    endtask

    task automatic test_reset_midwait();
        int cyc;
        logic [3:0] p, r;
        // ptr is 1 here, so button 1 is granted ahead of buttons 3 and 0.
        in = 4'b0010;
        wait_busy(10);
        total++;
        if (owner !== 2'd1) begin
            bad++;
            $display("FAIL midwait_owner: got %0d, want 1", owner);
        end
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({stable, press, release_pulse, busy, owner} !== 15'd0) begin
            bad++;
            $display("FAIL midwait_async: got stable=%b press=%b release=%b busy=%b owner=%0d, want all 0",
                     stable, press, release_pulse, busy, owner);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_pulse(60, cyc, p, r);
        total++;
        if (p !== 4'b0010 || r !== 4'b0000 || stable !== 4'b0010) begin
            bad++;
            $display("FAIL midwait_fresh: got press=%b release=%b stable=%b, want 0010 0000 0010", p, r, stable);
        end
    endtask

    initial begin
        reset = 1'b1;
        in    = 4'b0000;
        test_reset();
        test_single_press();
        test_bounce();
        test_all_press();
        test_release();
        test_wrap();
        test_reset_midwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_scan_arbiter.md
BUTTON_SCAN_ARBITER -- requirements
Module: button_scan_arbiter

Interface
REQ-001 The block SHALL have parameter sim, default 1'b0: 1 selects the simulation tick divider of 2, 0 selects 100000, giving 1 kHz at 100 MHz.
REQ-002 The block SHALL have parameter settle_ticks, default 10: the number of 1 kHz ticks in one debounce window.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in  input  4  raw, unsynchronized button levels, where 1 means pressed.
REQ-006 stable  output  4  debounced button levels.
REQ-007 press  output  4  one-cycle pulse per button on a debounced 0->1 change.
REQ-008 release  output  4  one-cycle pulse per button on a debounced 1->0 change.
REQ-009 busy  output  1  high while the shared timer is claimed, i.e. in states WAIT and CHECK.
REQ-010 owner  output  2  index of the button holding the timer; holds its last value when idle.

Function
REQ-011 Each in bit SHALL pass through a 2-flop synchronizer; sync[i] denotes the second flop output, and all decisions SHALL use sync only.
REQ-012 A free-running divider SHALL count 0..DIV-1 (DIV = 2 when sim, else 100000) and assert tick for one cycle when count == DIV-1.
REQ-013 One shared window counter SHALL serve all four buttons; no per-button timers.
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and CHECK.
REQ-015 IDLE: a button is a candidate when sync[i] != stable[i]; with no candidate, the FSM SHALL remain in IDLE.
REQ-016 IDLE with candidates: grant to the first candidate in circular order starting at ptr, latch it into owner, clear the window counter, and go to WAIT on the next edge.
REQ-017 WAIT: the window counter SHALL increment on each tick; when the counter equals settle_ticks-1 and tick is high, the FSM SHALL go to CHECK.
REQ-018 The window length SHALL therefore be settle_ticks full ticks minus at most one divider period of phase; no resynchronization of the divider is done.
REQ-019 CHECK (exactly one cycle): if sync[owner] != stable[owner], stable[owner] SHALL take sync[owner] at the end of CHECK.
REQ-020 In the same case, press[owner] (new level 1) or release[owner] (new level 0) SHALL be high in the cycle immediately after CHECK.
REQ-021 CHECK where sync[owner] == stable[owner] (input bounced back): stable SHALL be unchanged and no pulse SHALL be issued.
REQ-022 CHECK SHALL always set ptr to (owner+1) mod 4 and return to IDLE.
REQ-023 Input changes on the owner during WAIT SHALL be ignored; only the level sampled in CHECK counts.
REQ-024 Non-owner buttons that change during WAIT SHALL stay pending and be served in later grants, in round-robin order.
REQ-025 At most one bit of press|release SHALL be high in any cycle; press and release are registered outputs.
REQ-026 ptr SHALL wrap 3->0, and owner SHALL wrap with it.

Reset
REQ-027 On reset low, asynchronously: state = IDLE, stable = 0, press = 0, release = 0, owner = 0, ptr = 0, busy = 0, window counter = 0, divider = 0, synchronizer flops = 0.
REQ-028 Reset asserted mid-WAIT or mid-CHECK SHALL abort the window with no stable update and no pulse.
REQ-029 After reset release, a held button SHALL be detected afresh through IDLE.

Verification (sim = 1, settle_ticks = 10)
REQ-030 in = 0001 held steady -> busy rises, owner = 0, and after about 20 cycles stable = 0001 with press = 0001 for exactly one cycle.
REQ-031 in[0] set to 1, then returned to 0 mid-WAIT and held at 0 -> CHECK finds no change, stable stays 0000, and press/release stay 0.
REQ-032 in = 1111 applied in one cycle with ptr = 0 -> grants go in order 0, 1, 2, 3 with one press pulse each, ending at stable = 1111 and ptr = 0.
REQ-033 With stable = 0100, in[2] set to 0 and held -> release = 0100 for one cycle and stable = 0000.
REQ-034 Reset pulsed low during WAIT -> all outputs 0 immediately; after release with in held at 0010, a fresh window runs and press = 0010.
REQ-035 With ptr = 3, in = 1001 -> button 3 is granted before button 0, and ptr wraps to 0 and then 1.
